jk_cmd_driver: RTL and testbench

- Upstream stimulus stage for the master-slave JK flip-flop (m_s_ff).
- Accepts JK commands over a valid/ready handshake and drives the flip-flop's j/k inputs for a programmed number of cycles, then holds both low.
- Keeps a reference model of the expected q, compares it against the flip-flop's actual q after a settle window, and records mismatches.
- Replaces hand-timed j/k stimulus in simulation and on-board tests.

---
 rtl/jk_cmd_driver.sv | 166 ++++++++++++++++
 tb/tb_jk_cmd_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: accepts JK commands over valid/ready, drives j/k for a
// programmed number of cycles, lets the flip-flop settle, then compares its q
// against an internal reference model and records mismatches.
module jk_cmd_driver #(
    parameter int LEN_W  = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    output logic             exp_q,
    output logic             done,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    input  logic             clr_err
);

    // Settle counter only needs to hold the value SETTLE (SETTLE >= 1).
    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [1:0]         op_q,         op_d;
    logic [LEN_W-1:0]   cnt_q,        cnt_d;
    logic [SET_W-1:0]   settle_q,     settle_d;
    logic               ready_q,      ready_d;
    logic               j_q,          j_d;
    logic               k_q,          k_d;
    logic               exp_q_q,      exp_q_d;
    logic               done_q,       done_d;
    logic               mismatch_q,   mismatch_d;
    logic               sticky_q,     sticky_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;

    // State register: every output is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            cnt_q      <= '0;
            settle_q   <= '0;
            ready_q    <= 1'b1;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            exp_q_q    <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            ready_q    <= ready_d;
            j_q        <= j_d;
            k_q        <= k_d;
            exp_q_q    <= exp_q_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            sticky_q   <= sticky_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic: command sequencing, JK reference model, error tracking.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        ready_d    = 1'b0;
        j_d        = 1'b0;
        k_d        = 1'b0;
        exp_q_d    = exp_q_q;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        sticky_d   = sticky_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    cnt_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    state_d = ST_DRIVE;
                    ready_d = 1'b0;
                    // j/k appear the cycle after acceptance.
                    j_d     = cmd_op[1];
                    k_d     = cmd_op[0];
                end
            end
            ST_DRIVE: begin
                // The flip-flop sees this cycle's j/k at the closing edge,
                // so the model advances on the same edge.
                case (op_q)
                    2'b01:   exp_q_d = 1'b0;
                    2'b10:   exp_q_d = 1'b1;
                    2'b11:   exp_q_d = ~exp_q_q;
                    default: exp_q_d = exp_q_q;
                endcase
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d  = ST_SETTLE;
                    settle_d = SET_W'(SETTLE);
                end else begin
                    j_d = op_q[1];
                    k_d = op_q[0];
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) begin
                    state_d    = ST_CHECK;
                    done_d     = 1'b1;
                    mismatch_d = (q_in != exp_q_q);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                if (mismatch_q) begin
                    sticky_d = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Clearing wins over a mismatch being recorded on the same edge.
        if (clr_err) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end
    end

    assign cmd_ready  = ready_q;
    assign j          = j_q;
    assign k          = k_q;
    assign exp_q      = exp_q_q;
    assign done       = done_q;
    assign mismatch   = mismatch_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Scoreboard bench for jk_cmd_driver: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever done pulses.
module tb_jk_cmd_driver;

    localparam int LEN_W   = 4;
    localparam int SETTLE  = 2;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             j, k;
    logic             q_in;
    logic             exp_q, done, mismatch, err_sticky;
    logic [ERR_W-1:0] err_count;
    logic             clr_err = 1'b0;

    jk_cmd_driver #(.LEN_W(LEN_W), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .q_in(q_in),
        .exp_q(exp_q), .done(done), .mismatch(mismatch),
        .err_sticky(err_sticky), .err_count(err_count), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the master-slave JK flip-flop, with an override for q.
    logic ff_q;
    logic force_en = 1'b0, force_val = 1'b0;
    always @(posedge clk) begin
        if (rst) ff_q <= 1'b0;
        else case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end
    assign q_in = force_en ? force_val : ff_q;

    typedef struct {
        logic [1:0] op;
        int         len;
        logic       eq;
        logic       mis;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference state: expected q and expected error counter/flag.
    logic model_q      = 1'b0;
    int   model_err    = 0;
    bit   model_sticky = 1'b0;
    bit   pend_v = 1'b0, pend_mis = 1'b0, pend_chk = 1'b0;
    int   drive_cnt = 0;
    bit   rnd_clr_en = 1'b0;

    // Monitor: inputs change at negedge+1, so values read here are the ones
    // the preceding rising edge sampled.
    always @(negedge clk) begin
        if (rst) begin
            model_err    = 0;
            model_sticky = 1'b0;
            pend_v       = 1'b0;
            drive_cnt    = 0;
        end else begin
            pend_chk = pend_v;
            if (clr_err) begin
                model_err    = 0;
                model_sticky = 1'b0;
            end else if (pend_v && pend_mis) begin
                if (model_err < ERR_MAX) model_err++;
                model_sticky = 1'b1;
            end
            pend_v = 1'b0;
            if (pend_chk) begin
                chk("err_count", int'(err_count), model_err);
                chk("err_sticky", int'(err_sticky), int'(model_sticky));
            end
            if (j || k) begin
                if (sbq.size() == 0) chk("drive_without_cmd", 1, 0);
                else begin
                    chk("jk_code", int'({j, k}), int'(sbq[0].op));
                    drive_cnt++;
                end
            end
            if (done) begin
                if (sbq.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    mon_e = sbq.pop_front();
                    chk("exp_q", int'(exp_q), int'(mon_e.eq));
                    chk("mismatch", int'(mismatch), int'(mon_e.mis));
                    chk("done_latency", cyc - mon_e.acc, mon_e.len + SETTLE);
                    chk("drive_cycles", drive_cnt, (mon_e.op == 2'b00) ? 0 : mon_e.len);
                    chk("ready_in_check", int'(cmd_ready), 0);
                    drive_cnt = 0;
                    pend_v    = 1'b1;
                    pend_mis  = mon_e.mis;
                end
            end
        end
    end

    // Issue one command once the driver is ready; push its expected outcome.
    task automatic send(input logic [1:0] op, input int len, input logic fen, input logic fval);
        bit   rdy;
        int   leff;
        logic nq;
        exp_t e;
        rdy = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (cmd_ready) begin
                rdy = 1'b1;
                break;
            end
        end
        if (!rdy) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        leff = (len == 0) ? 1 : len;
        case (op)
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            2'b11:   nq = model_q ^ logic'(leff % 2);
            default: nq = model_q;
        endcase
        force_en  = fen;
        force_val = fval;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        e.op  = op;
        e.len = leff;
        e.eq  = nq;
        e.mis = fen ? (fval != nq) : 1'b0;
        e.acc = cyc + 1;
        sbq.push_back(e);
        model_q = nq;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_len   = LEN_W'($urandom_range(0, 15));
    endtask

    // Valid pulse while the driver is busy; it must be ignored.
    task automatic spurious_valid();
        chk("ready_low_in_drive", int'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        @(negedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk); #1;
            if (sbq.size() == 0 && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Random clear pulses while enabled, exercising clear-vs-mismatch priority.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (rnd_clr_en) clr_err = ($urandom_range(0, 15) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_jk", int'({j, k}), 0);
        chk("rst_exp_q", int'(exp_q), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        chk("rst_err_count", int'(err_count), 0);
        #1 rst = 1'b0;

        // Directed sequence
        send(2'b10, 3, 1'b0, 1'b0);
        send(2'b01, 5, 1'b0, 1'b0);
        send(2'b11, 4, 1'b0, 1'b0);
        send(2'b11, 3, 1'b0, 1'b0);
        send(2'b10, 0, 1'b0, 1'b0);
        spurious_valid();
        send(2'b00, 2, 1'b0, 1'b0);
        send(2'b00, 1, 1'b1, 1'b0);
        drain();

        // Randomized commands with occasional forced q and random clears
        rnd_clr_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 3)), $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) spurious_valid();
        end
        drain();
        rnd_clr_en = 1'b0;
        clr_err    = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Saturation: 300 forced mismatches
        for (int n = 0; n < 300; n++) send(2'b10, 1, 1'b1, 1'b0);
        drain();
        chk("sat_err_count", int'(err_count), ERR_MAX);
        chk("sat_sticky", int'(err_sticky), 1);
        clr_err = 1'b1;
        @(negedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_sticky", int'(err_sticky), 0);
        #1;

        // Reset in the middle of DRIVE
        send(2'b10, 10, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_jk", int'({j, k}), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_exp_q", int'(exp_q), 0);
        chk("midrst_done", int'(done), 0);
        #1;
        rst = 1'b0;
        sbq.delete();
        model_q  = 1'b0;
        force_en = 1'b0;
        repeat (20) @(negedge clk);
        #1;

        // Normal operation resumes after reset
        send(2'b11, 1, 1'b0, 1'b0);
        drain();
        chk("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
